free_list_2way: RTL and testbench
=================================

// Module: free_list_2way
// PURPOSE
//  Two-wide free list of physical register tags for the out-of-order core.
//  Supplies up to two free PR tags per cycle to dispatch, which routes them to the ROB, RS and map table.
//  Takes back up to two Told tags per cycle from ROB retirement.
//  Implemented as a circular FIFO with head (allocate) and tail (return) pointers and an occupancy counter.
// PARAMETERS
//  PR_NUM    64  number of physical registers
//  ARCH_NUM  32  architectural registers; PR 0..ARCH_NUM-1 are mapped at reset
//  TAG_W     7   physical tag width
//  DEPTH     32  FIFO entries (PR_NUM-ARCH_NUM); must be a power of two
// PORTS
//  clock              in   1      system clock, rising edge
//  reset              in   1      asynchronous, active-high
//  id_dispatch_num    in   2      tags consumed by dispatch this cycle (0..2)
//  rob_retire_num     in   2      tags returned by retire this cycle (0..2)
//  rob_retire_tag_a   in   TAG_W  first returned Told tag
//  rob_retire_tag_b   in   TAG_W  second returned Told tag (used only when num=2)
//  fl_pr0             out  TAG_W  tag at head
//  fl_pr1             out  TAG_W  tag at head+1
//  fl_cap             out  2      min(count,2): how many tags dispatch may take
//  fl_count           out  6      current occupancy (0..DEPTH)
//  fl_error           out  1      sticky protocol-error flag
// BEHAVIOUR
//  - Reset (async): entry i = ARCH_NUM+i, head=0, tail=0 (full), count=DEPTH, error=0.
//    Outputs after reset: fl_pr0=32, fl_pr1=33, fl_cap=2, fl_count=32, fl_error=0.
//  - fl_pr0, fl_pr1 and fl_cap are combinational reads of registered state, so dispatch sees them in the same cycle.
//  - When fl_cap<2, fl_pr1 is don't-care. When fl_cap=0, fl_pr0 is also don't-care.
//  - Allocate, on the clock edge:
//    - If id_dispatch_num<=fl_cap, head += num.
//    - Else (num>fl_cap, or num=3): no allocation and error<=1.
//  - Return, on the clock edge:
//    - num=1: mem[tail]=tag_a, tail+=1.
//    - num=2: mem[tail]=tag_a, mem[tail+1]=tag_b, tail+=2.
//    - num=3: no write and error<=1.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. No special case at the wrap boundary.
//  - Simultaneous allocate and return in one cycle:
//    - Both apply.
//    - fl_cap is based on the pre-edge count, so a returned tag can be allocated no earlier than the next cycle.
//    - count_next = count - granted_alloc + accepted_ret.
//  - Overflow: if count - granted_alloc + ret_num > DEPTH, error<=1.
//    - Accept only the returns that fit, tag_a before tag_b.
//    - Surplus tags are dropped; no live entry is ever overwritten.
//  - Empty: count=0 gives fl_cap=0. Any nonzero dispatch request sets error and is ignored.
//  - Returned tags are not checked for duplicates or range.
//  - error clears only on reset.
//  - Reset asserted mid-operation restores the full reset image immediately.
//    - Allocations and returns in that cycle are lost.
//  - Latency: return-to-availability is 1 cycle. Allocate pointer advance is visible 1 cycle later.
// TESTING
//  T1 reset
//     Assert reset -> pr0=32, pr1=33, cap=2, count=32, error=0, with no clock edge needed.
//  T2 drain
//     dispatch_num=2 for 16 cycles -> pr0/pr1 pairs (32,33),(34,35)..(62,63).
//     Then count=0, cap=0, error=0.
//  T3 underflow
//     At count=1, dispatch_num=2 -> head unchanged, count=1, error=1.
//  T4 return while empty
//     At count=0, retire_num=2 with tags 5,9 and dispatch 0 -> next cycle pr0=5, pr1=9, cap=2, count=2.
//  T5 simultaneous, across wrap
//     At head=31, count=1, dispatch 1 + retire 2 (tags 40,41) -> count=2.
//     pr0 is read from entry 0 and equals 40; pr1=41.
//  T6 overflow
//     At count=31, retire 2 (tags 7,8) with no dispatch -> count=32, tag 7 stored, tag 8 dropped, error=1.

Source files
------------

// File: rtl/free_list_2way.sv
// Two-wide circular free list of physical register tags: up to two allocations
// to dispatch and up to two returns from retirement per cycle.
module free_list_2way #(
    parameter int PR_NUM   = 64,
    parameter int ARCH_NUM = 32,
    parameter int TAG_W    = 7,
    parameter int DEPTH    = PR_NUM - ARCH_NUM,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [1:0]       id_dispatch_num_i,
    input  logic [1:0]       rob_retire_num_i,
    input  logic [TAG_W-1:0] rob_retire_tag_a_i,
    input  logic [TAG_W-1:0] rob_retire_tag_b_i,
    output logic [TAG_W-1:0] fl_pr0_o,
    output logic [TAG_W-1:0] fl_pr1_o,
    output logic [1:0]       fl_cap_o,
    output logic [CNT_W-1:0] fl_count_o,
    output logic             fl_error_o
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic [1:0]       cap;
    logic             alloc_ok;
    logic [1:0]       alloc_num;
    logic [1:0]       ret_req;
    logic [1:0]       ret_acc;
    logic             ret_overflow;
    logic [CNT_W-1:0] live;
    logic [CNT_W-1:0] space;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    always_comb begin
        cap          = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
        alloc_ok     = (id_dispatch_num_i <= cap);
        alloc_num    = alloc_ok ? id_dispatch_num_i : 2'd0;
        live         = count_q - CNT_W'(alloc_num);
        // Free slots after this cycle's allocation; returns may reuse them at once.
        space        = CNT_W'(DEPTH) - live;
        ret_req      = (rob_retire_num_i == 2'd3) ? 2'd0 : rob_retire_num_i;
        ret_overflow = (CNT_W'(ret_req) > space);
        ret_acc      = ret_overflow ? space[1:0] : ret_req;

        head_d  = head_q + PTR_W'(alloc_num);
        tail_d  = tail_q + PTR_W'(ret_acc);
        count_d = live + CNT_W'(ret_acc);
        error_d = error_q | ~alloc_ok | (rob_retire_num_i == 2'd3) | ret_overflow;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(ARCH_NUM + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
            error_q <= 1'b0;
        end else begin
            if (ret_acc != 2'd0) begin
                mem_q[tail_q] <= rob_retire_tag_a_i;
            end
            if (ret_acc == 2'd2) begin
                mem_q[tail_p1] <= rob_retire_tag_b_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign fl_pr0_o   = mem_q[head_q];
    assign fl_pr1_o   = mem_q[head_p1];
    assign fl_cap_o   = cap;
    assign fl_count_o = count_q;
    assign fl_error_o = error_q;

endmodule

// File: tb/tb_free_list_2way.sv
// Bench for free_list_2way: directed scenarios then random traffic, checked
// against a queue-based model of the free list.
module tb_free_list_2way;

    logic       clk;
    logic       rst;
    logic [1:0] disp_num;
    logic [1:0] ret_num;
    logic [6:0] tag_a;
    logic [6:0] tag_b;
    logic [6:0] pr0;
    logic [6:0] pr1;
    logic [1:0] cap;
    logic [5:0] count;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] fq[$];
    logic       m_err;

    free_list_2way dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .id_dispatch_num_i  (disp_num),
        .rob_retire_num_i   (ret_num),
        .rob_retire_tag_a_i (tag_a),
        .rob_retire_tag_b_i (tag_b),
        .fl_pr0_o           (pr0),
        .fl_pr1_o           (pr1),
        .fl_cap_o           (cap),
        .fl_count_o         (count),
        .fl_error_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_cap();
        return (fq.size() >= 2) ? 2 : fq.size();
    endfunction

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(7'(32 + i));
        m_err = 1'b0;
    endtask

    task automatic model_push(input logic [6:0] t);
        if (fq.size() < 32) fq.push_back(t);
        else m_err = 1'b1;
    endtask

    task automatic model_step(input int d, input int r, input logic [6:0] a, input logic [6:0] b);
        if (d <= m_cap()) begin
            for (int k = 0; k < d; k++) void'(fq.pop_front());
        end else begin
            m_err = 1'b1;
        end
        if (r == 3) m_err = 1'b1;
        else begin
            if (r >= 1) model_push(a);
            if (r == 2) model_push(b);
        end
    endtask

    task automatic check_outputs(input string ph);
        int c;
        c = m_cap();
        chk({ph, "_cap"},   32'(cap),   32'(c));
        chk({ph, "_count"}, 32'(count), 32'(fq.size()));
        chk({ph, "_err"},   32'(err),   32'(m_err));
        if (c >= 1) chk({ph, "_pr0"}, 32'(pr0), 32'(fq[0]));
        if (c == 2) chk({ph, "_pr1"}, 32'(pr1), 32'(fq[1]));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input string ph, input int d, input int r,
                        input logic [6:0] a, input logic [6:0] b);
        @(negedge clk);
        disp_num = 2'(d);
        ret_num  = 2'(r);
        tag_a    = a;
        tag_b    = b;
        #1;
        check_outputs(ph);
        @(posedge clk);
        model_step(d, r, a, b);
        #1;
        disp_num = 2'd0;
        ret_num  = 2'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c, d, r, fr;
        rst      = 1'b1;
        disp_num = 2'd0;
        ret_num  = 2'd0;
        tag_a    = 7'd0;
        tag_b    = 7'd0;
        model_reset();
        #1;
        chk("t1_pr0",   32'(pr0),   32'd32);
        chk("t1_pr1",   32'(pr1),   32'd33);
        chk("t1_cap",   32'(cap),   32'd2);
        chk("t1_count", 32'(count), 32'd32);
        chk("t1_err",   32'(err),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // T2: drain in pairs
        for (int k = 0; k < 16; k++) begin
            settle();
            chk("t2_pr0", 32'(pr0), 32'(32 + 2 * k));
            chk("t2_pr1", 32'(pr1), 32'(33 + 2 * k));
            step("t2", 2, 0, 7'd0, 7'd0);
        end
        settle();
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_cap",   32'(cap),   32'd0);
        chk("t2_err",   32'(err),   32'd0);

        // T3: underflow at count 1
        step("t3a", 0, 1, 7'd20, 7'd0);
        step("t3b", 2, 0, 7'd0, 7'd0);
        settle();
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_err",   32'(err),   32'd1);
        chk("t3_pr0",   32'(pr0),   32'd20);

        // T4: return while empty
        step("t4a", 1, 0, 7'd0, 7'd0);
        step("t4b", 0, 2, 7'd5, 7'd9);
        settle();
        chk("t4_pr0",   32'(pr0),   32'd5);
        chk("t4_pr1",   32'(pr1),   32'd9);
        chk("t4_cap",   32'(cap),   32'd2);
        chk("t4_count", 32'(count), 32'd2);

        // T5: simultaneous allocate/return across the pointer wrap
        do_reset();
        for (int k = 0; k < 15; k++) step("t5a", 2, 0, 7'd0, 7'd0);
        step("t5b", 1, 0, 7'd0, 7'd0);
        settle();
        chk("t5_count_pre", 32'(count), 32'd1);
        step("t5c", 1, 2, 7'd40, 7'd41);
        settle();
        chk("t5_count", 32'(count), 32'd2);
        chk("t5_pr0",   32'(pr0),   32'd40);
        chk("t5_pr1",   32'(pr1),   32'd41);
        chk("t5_err",   32'(err),   32'd0);

        // T6: overflow drops the surplus tag only
        for (int k = 0; k < 29; k++) step("t6a", 0, 1, 7'($urandom_range(0, 127)), 7'd0);
        settle();
        chk("t6_count_pre", 32'(count), 32'd31);
        step("t6b", 0, 2, 7'd7, 7'd8);
        settle();
        chk("t6_count", 32'(count), 32'd32);
        chk("t6_err",   32'(err),   32'd1);
        for (int k = 0; k < 15; k++) step("t6c", 2, 0, 7'd0, 7'd0);
        settle();
        chk("t6_pr1_tag7", 32'(pr1),   32'd7);
        chk("t6_count2",   32'(count), 32'd2);

        // Mid-operation reset must clear the sticky error immediately
        do_reset();

        // Random legal traffic
        for (int k = 0; k < 400; k++) begin
            c  = m_cap();
            d  = $urandom_range(0, c);
            fr = 32 - (fq.size() - d);
            r  = $urandom_range(0, (fr >= 2) ? 2 : fr);
            step("rnd_legal", d, r, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        end
        settle();
        chk("rnd_legal_err", 32'(err), 32'd0);

        // Random unrestricted traffic, including protocol errors
        do_reset();
        for (int k = 0; k < 400; k++) begin
            d = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            step("rnd_any", d, r, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            if (k == 200) do_reset();
        end
        settle();
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
